// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO serial reader.
// FSM state encodings, frame geometry and line idle level.
package fifo_ser_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  localparam int FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

  // index of the final payload bit (start and stop excluded)
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    POP   = ST_POP,
    LOAD  = ST_LOAD,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

endpackage

// File: rtl/fifo_serial_reader_bit_timer.sv
// Bit-period timer: tick on the last cycle of each bit period.
// Ports: clk, rst (async active-low), clr in; tick, pre_tick out.
module bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick     = (cnt == LAST);
  // one cycle ahead of tick, lets frame_done be registered
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/fifo_serial_reader.sv
// Pops bytes from an 8-bit FIFO and sends them as 8N1 serial frames.
// Ports: clk, rst (async low), fifo_empty, fifo_data in; fifo_read, tx, busy, frame_done out.
module fifo_serial_reader
  import fifo_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  state_t            state, state_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic              tx_d;
  logic              tick, pre_tick, clr;

  // timer held at zero until the frame starts
  assign clr = (state == IDLE) || (state == POP) || (state == LOAD);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    unique case (state)
      IDLE:  if (!fifo_empty) state_d = POP;
      POP:   state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
        state_d = START;
      end
      START: if (tick) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (tick) begin
        shift_d   = shift >> 1;
        bit_cnt_d = bit_cnt + 3'd1;
        if (bit_cnt == LAST_BIT) state_d = STOP;
      end
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs are decoded from next-state values and then registered
  always_comb begin
    tx_d = IDLE_LEVEL;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      tx         <= IDLE_LEVEL;
      fifo_read  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      bit_cnt    <= bit_cnt_d;
      tx         <= tx_d;
      fifo_read  <= (state_d == POP);
      busy       <= (state_d != IDLE);
      frame_done <= (state == STOP) && pre_tick;
    end
  end

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Bench for fifo_serial_reader with a behavioural FIFO.
// Table vectors, corner sequences and random bytes vs a frame model.
module tb_fifo_serial_reader;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read, tx, busy, frame_done;

  logic [7:0] mem [256];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int reads = 0;
  int dbl = 0;
  int bad_reads = 0;
  logic prev_read = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs [4];
  logic [7:0] model_q [$];

  fifo_serial_reader #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_read) begin
      if (wr_cnt == rd_cnt)
        bad_reads <= bad_reads + 1;
      else begin
        fifo_data <= mem[rd_cnt[7:0]];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (fifo_read) reads <= reads + 1;
    if (fifo_read && prev_read) dbl <= dbl + 1;
    prev_read <= fifo_read;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt[7:0]] = b;
    wr_cnt++;
  endtask

  task automatic expect_frame(input logic [9:0] pat, input string nm,
                              output int waited);
    logic [2:0] exp;
    waited = 0;
    while (tx !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      chk({nm, " start"}, int'(tx), 0);
      return;
    end
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i > 0) @(negedge clk);
      exp = {1'b1, pat[i / CPB], (i == 10 * CPB - 1)};
      chk({nm, " busy/tx/done"}, int'({busy, tx, frame_done}), int'(exp));
    end
  endtask

  initial begin
    int w, n, r0;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};

    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset outputs", int'({tx, busy, fifo_read, frame_done}), 8);
    end
    rst = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("empty idle", int'({tx, busy, fifo_read}), 4);
    end
    chk("empty reads", reads, 0);

    r0 = reads;
    push(vecs[0].data);
    expect_frame(vecs[0].frame, "single A5", w);
    chk("single reads", reads - r0, 1);

    r0 = reads;
    for (int i = 1; i < 4; i++) push(vecs[i].data);
    for (int i = 1; i < 4; i++) begin
      expect_frame(vecs[i].frame, $sformatf("burst %0d", i), w);
      if (i > 1) chk("burst gap", w - 1, 3);
    end
    chk("burst reads", reads - r0, 3);

    // new data arrives while a frame is in DATA
    push(8'h5A);
    n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB + 8) @(negedge clk);
    r0 = reads;
    push(8'hC3);
    n = 0;
    while (frame_done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("drop done seen", int'(frame_done), 1);
    chk("no read mid frame", reads - r0, 0);
    n = 0;
    while (fifo_read !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("pop after done", n, 2);
    expect_frame({1'b1, 8'hC3, 1'b0}, "drop C3", w);

    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      model_q.push_back(b);
      push(b);
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        model_q.push_back(b);
        push(b);
      end
      while (model_q.size() > 0) begin
        b = model_q.pop_front();
        expect_frame({1'b1, b, 1'b0}, $sformatf("rand %02h", b), w);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // reset in the middle of data bit 3 of 0xF0 (bit 3 is 0)
    push(8'hF0);
    n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rst frame start", int'(tx), 0);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    chk("bit3 low", int'(tx), 0);
    rst = 1'b0;
    #1;
    chk("async reset", int'({tx, busy, fifo_read, frame_done}), 8);
    @(negedge clk);
    rst = 1'b1;
    r0 = reads;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("post reset idle", int'({tx, busy, frame_done}), 4);
    end
    chk("post reset reads", reads - r0, 0);

    chk("double read pulses", dbl, 0);
    chk("read while empty", bad_reads, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
